// File: rtl/rs232_pkg.sv
// Shared constants and width helpers for the RS232 receive path.
package rs232_pkg;

    localparam int unsigned BYTE_W = 8;

    // Pointer width for a power-of-two buffer of the given depth.
    function automatic int unsigned ptr_width(input int unsigned depth);
        return $clog2(depth);
    endfunction

    // Occupancy width: one extra bit so the full depth itself is representable.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_core.sv
// Single-clock byte FIFO: storage, wrapping pointers, occupancy count and push/pop arbitration.
module sync_fifo_core
    import rs232_pkg::*;
#(
    parameter int unsigned DEPTH = 16
)
(
    input  logic                          clock,
    input  logic                          reset,
    input  logic [BYTE_W-1:0]             wr_data,
    input  logic                          wr_valid,
    output logic [BYTE_W-1:0]             rd_data_c,
    output logic                          rd_valid_c,
    input  logic                          rd_ready,
    output logic [cnt_width(DEPTH)-1:0]   count,
    output logic [cnt_width(DEPTH)-1:0]   count_next_c,
    output logic                          drop_c
);

    localparam int unsigned PTR_W = ptr_width(DEPTH);
    localparam int unsigned CNT_W = cnt_width(DEPTH);

    logic [BYTE_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              push;
    logic              pop;

    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    always_comb begin
        rd_valid_c   = (count != '0);
        rd_data_c    = mem[rd_ptr];
        pop          = rd_valid_c && rd_ready;
        push         = wr_valid && ((count < CNT_W'(DEPTH)) || pop);
        drop_c       = wr_valid && !push;
        count_next_c = count + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count_next_c;
        end
    end

    // Storage carries no reset; contents are meaningless until written.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/rs232_rx_fifo.sv
// Receive-side byte buffer: FIFO plus CTS flow control with hysteresis and a sticky drop flag.
module rs232_rx_fifo
    import rs232_pkg::*;
#(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned HIGH_WATER = 12,
    parameter int unsigned LOW_WATER  = 4
)
(
    input  logic                          clock,
    input  logic                          reset,
    input  logic [BYTE_W-1:0]             in_data,
    input  logic                          in_valid,
    output logic [BYTE_W-1:0]             out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          rs232_ctsn,
    output logic                          overflow,
    input  logic                          overflow_clear,
    output logic [cnt_width(DEPTH)-1:0]   count
);

    localparam int unsigned CNT_W = cnt_width(DEPTH);

    logic [CNT_W-1:0] count_next_c;
    logic             drop_c;

    sync_fifo_core #(
        .DEPTH        (DEPTH)
    ) u_core (
        .clock        (clock),
        .reset        (reset),
        .wr_data      (in_data),
        .wr_valid     (in_valid),
        .rd_data_c    (out_data),
        .rd_valid_c   (out_valid),
        .rd_ready     (out_ready),
        .count        (count),
        .count_next_c (count_next_c),
        .drop_c       (drop_c)
    );

    // CTS follows next-cycle occupancy so the host sees "stop" the moment the mark is reached.
    always_ff @(posedge clock) begin
        if (reset) begin
            rs232_ctsn <= 1'b1;
            overflow   <= 1'b0;
        end else begin
            if (count_next_c >= CNT_W'(HIGH_WATER))
                rs232_ctsn <= 1'b1;
            else if (count_next_c <= CNT_W'(LOW_WATER))
                rs232_ctsn <= 1'b0;

            if (drop_c)
                overflow <= 1'b1;
            else if (overflow_clear)
                overflow <= 1'b0;
        end
    end

endmodule
